prog_loader: RTL

Byte-stream program loader: the writer side of the CPU's instruction-memory path. The CPU only reads RAM during fetcha/fetchb; this block fills RAM with a program from an external byte source.
- Holds the CPU in await via halt, receives a length/payload/checksum frame, and writes the payload into RAM through the RAM write port (addr/data/wren).
- On a valid checksum it pulses run so the stage controller starts fetching from BASE_ADDR.

---
 rtl/prog_loader_pkg.sv | 11 +
 rtl/prog_loader_wr_port.sv | 42 ++++
 rtl/prog_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, frame field names and constants for the program loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_HALT_WAIT, S_LEN, S_DATA, S_CSUM, S_RUN, S_DONE, S_ERR
  } state_e;
  typedef enum logic [1:0] {F_LEN, F_DATA, F_CSUM} field_e;
  localparam int LEN_ILLEGAL = 0;
  function automatic logic halt_state(input state_e s);
    return s inside {S_HALT_WAIT, S_LEN, S_DATA, S_CSUM, S_ERR};
  endfunction
endpackage

// File: rtl/prog_loader_wr_port.sv
// loader_wr_port: registered RAM write port with payload counter and address wrap.
module loader_wr_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] count
);
  logic [ADDR_W-1:0] addr_q, addr_d, count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  always_comb begin
    wren_d  = wr;
    addr_d  = wr ? ADDR_W'(BASE_ADDR) + count_q : addr_q;
    data_d  = wr ? wdata : data_q;
    count_d = clr ? '0 : wr ? count_q + ADDR_W'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      count_q <= count_d;
    end
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_wren = wren_q;
  assign count    = count_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a LEN/payload/CSUM byte frame, writes the payload to RAM while holding the CPU halted.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BASE_ADDR = 0,
  parameter int AUTO_RUN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  input  logic              cpu_await,
  output logic              cpu_halt,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d, acc_q, acc_d;
  logic              ready_q, halt_q, run_q, busy_q, done_q, err_q;
  logic              xfer, idle_like;
  assign xfer      = byte_valid & ready_q;
  assign idle_like = state_q inside {S_IDLE, S_DONE, S_ERR};
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (start) begin
          state_d = S_HALT_WAIT;
          acc_d   = '0;
        end
      S_HALT_WAIT: state_d = cpu_await ? S_LEN : S_HALT_WAIT;
      S_LEN:
        if (xfer) begin
          state_d = (byte_data == DATA_W'(LEN_ILLEGAL)) ? S_ERR : S_DATA;
          rem_d   = byte_data;
        end
      S_DATA:
        if (xfer) begin
          acc_d   = acc_q + byte_data;
          rem_d   = rem_q - DATA_W'(1);
          state_d = (rem_q == DATA_W'(1)) ? S_CSUM : S_DATA;
        end
      S_CSUM:
        if (xfer) state_d = (acc_q != byte_data) ? S_ERR : (AUTO_RUN != 0) ? S_RUN : S_DONE;
      S_RUN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // Status outputs are decoded from the next state so they are flops aligned with state_q.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      halt_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      ready_q <= state_d inside {S_LEN, S_DATA, S_CSUM};
      halt_q  <= halt_state(state_d);
      run_q   <= state_d == S_RUN;
      busy_q  <= state_d inside {S_HALT_WAIT, S_LEN, S_DATA, S_CSUM};
      done_q  <= state_d == S_DONE;
      err_q   <= state_d == S_ERR;
    end
  loader_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR)) u_wr (
    .clk(clk), .rst(rst), .clr(idle_like & start), .wr(xfer & (state_q == S_DATA)),
    .wdata(byte_data), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .count(count)
  );
  assign byte_ready = ready_q;
  assign cpu_halt   = halt_q;
  assign cpu_run    = run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule
